// File: rtl/seg_pkg.sv
// Shared types and constants for the scrolling seven-segment scan controller.
package seg_pkg;

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } scan_state_e;

   localparam int NUM_DIGITS = 8;

   // Segment order is {a,b,c,d,e,f,g}, active-high.
   localparam logic [6:0] HEX7SEG [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
   };

endpackage

// File: rtl/seg_decode.sv
// Combinational hex-to-seven-segment lookup.
module seg_decode
   import seg_pkg::*;
(
   input  logic [3:0] code_i,
   output logic [6:0] seg_o
);

   assign seg_o = HEX7SEG[code_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 8-digit seven-segment scanner with a blanking gap between slots
// and a timed scroll offset into an 8-entry message buffer.
//
// state | meaning
// ------+---------------------------------------------------------
// BLANK | all digits off for BLANK_CYC cycles (anti-ghosting gap)
// SHOW  | digit digit_q lit for SCAN_DIV cycles
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int SCAN_DIV  = 50_000,
   parameter int BLANK_CYC = 500,
   parameter int STEP_DIV  = 25_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [2:0] load_idx,
   input  logic [3:0] load_code,
   input  logic       scroll_en,
   input  logic       pause,
   output logic [6:0] out,
   output logic [7:0] sel,
   output logic [2:0] offset
);

   localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int SW      = $clog2(STEP_DIV + 1);

   scan_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    digit_q, digit_d;
   logic [SW-1:0] step_q, step_d;
   logic [2:0]    offset_q, offset_d;
   logic [3:0]    msg_q [NUM_DIGITS];
   logic [2:0]    rd_idx;
   logic [6:0]    seg_w;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= BLANK;
         cnt_q    <= '0;
         digit_q  <= '0;
         step_q   <= '0;
         offset_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         digit_q  <= digit_d;
         step_q   <= step_d;
         offset_q <= offset_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      digit_d = digit_q;
      case (state_q)
         BLANK: begin
            if (cnt_q == CW'(BLANK_CYC - 1)) begin
               state_d = SHOW;
               cnt_d   = '0;
            end
         end
         SHOW: begin
            if (cnt_q == CW'(SCAN_DIV - 1)) begin
               state_d = BLANK;
               cnt_d   = '0;
               digit_d = digit_q + 3'd1;
            end
         end
         default: begin
            state_d = BLANK;
            cnt_d   = '0;
         end
      endcase
   end

   // Disabling scroll restarts the step interval; pause only freezes it.
   always_comb begin
      step_d   = step_q;
      offset_d = offset_q;
      if (!scroll_en) begin
         step_d = '0;
      end else if (!pause) begin
         if (step_q == SW'(STEP_DIV - 1)) begin
            step_d   = '0;
            offset_d = offset_q + 3'd1;
         end else begin
            step_d = step_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_DIGITS; i++) msg_q[i] <= '0;
      end else if (load) begin
         msg_q[load_idx] <= load_code;
      end
   end

   // 3-bit add gives the mod-8 wrap for free.
   assign rd_idx = digit_q + offset_q;

   seg_decode u_decode (
      .code_i (msg_q[rd_idx]),
      .seg_o  (seg_w)
   );

   always_comb begin
      sel = 8'hFF;
      out = 7'b0000000;
      if (state_q == SHOW) begin
         sel = ~(8'b1 << digit_q);
         out = seg_w;
      end
   end

   assign offset = offset_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with SCAN_DIV=4, BLANK_CYC=1, STEP_DIV=64.
module tb_seg_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       load;
   logic [2:0] load_idx;
   logic [3:0] load_code;
   logic       scroll_en;
   logic       pause;
   logic [6:0] out;
   logic [7:0] sel;
   logic [2:0] offset;

   int checks   = 0;
   int failures = 0;

   localparam logic [6:0] SEG_0 = 7'b1111110;
   localparam logic [6:0] SEG_1 = 7'b0110000;
   localparam logic [6:0] SEG_2 = 7'b1101101;
   localparam logic [6:0] SEG_4 = 7'b0110011;
   localparam logic [6:0] SEG_7 = 7'b1110000;
   localparam logic [6:0] SEG_8 = 7'b1111111;
   localparam logic [6:0] SEG_F = 7'b1000111;

   seg_scan_ctrl #(
      .SCAN_DIV  (4),
      .BLANK_CYC (1),
      .STEP_DIV  (64)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .load_idx  (load_idx),
      .load_code (load_code),
      .scroll_en (scroll_en),
      .pause     (pause),
      .out       (out),
      .sel       (sel),
      .offset    (offset)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      checks++;
      assert ($countones(~sel) <= 1) else begin
         failures++;
         $error("FAIL sel_onehot observed=%0h expected=at_most_one_low", sel);
      end
   end

   initial begin
      rst = 1'b1; load = 1'b0; load_idx = '0; load_code = '0;
      scroll_en = 1'b0; pause = 1'b0;
      tick(2);
      check("rst_sel", sel, 8'hFF);
      check("rst_out", {1'b0, out}, 8'h00);
      check("rst_offset", {5'b0, offset}, 8'h00);

      // Scenario 1: scan timing, p counts edges since release
      rst = 1'b0;
      check("s1_blank_sel", sel, 8'hFF);
      tick(1);                                   // p=1
      check("s1_d0_sel", sel, 8'hFE);
      check("s1_d0_out", {1'b0, out}, {1'b0, SEG_0});
      tick(3);                                   // p=4
      check("s1_d0_last_sel", sel, 8'hFE);
      tick(1);                                   // p=5
      check("s1_gap_sel", sel, 8'hFF);
      check("s1_gap_out", {1'b0, out}, 8'h00);
      tick(1);                                   // p=6
      check("s1_d1_sel", sel, 8'hFD);
      tick(35);                                  // p=41
      check("s1_frame_sel", sel, 8'hFE);

      // Scenario 2: load codes 1..8
      for (int i = 0; i < 8; i++) begin
         load = 1'b1; load_idx = i[2:0]; load_code = 4'(i + 1);
         tick(1);
      end
      load = 1'b0;                               // p=49
      tick(7);                                   // p=56
      check("s2_d3_sel", sel, 8'hF7);
      check("s2_d3_out", {1'b0, out}, {1'b0, SEG_4});
      tick(20);                                  // p=76
      check("s2_d7_sel", sel, 8'h7F);
      check("s2_d7_out", {1'b0, out}, {1'b0, SEG_8});

      // Scenario 5: overwrite entry 0 while digit 0 is lit
      tick(5);                                   // p=81
      check("s5_before_out", {1'b0, out}, {1'b0, SEG_1});
      load = 1'b1; load_idx = 3'd0; load_code = 4'hF;
      tick(1);                                   // p=82
      load = 1'b0;
      check("s5_after_out", {1'b0, out}, {1'b0, SEG_F});
      check("s5_after_sel", sel, 8'hFE);

      // Scenario 3: scrolling, steps at p=82+64k
      scroll_en = 1'b1;
      tick(63);                                  // p=145
      check("s3_pre_step", {5'b0, offset}, 8'h00);
      tick(1);                                   // p=146
      check("s3_step1", {5'b0, offset}, 8'h01);
      check("s3_midshow_sel", sel, 8'hDF);
      check("s3_midshow_out", {1'b0, out}, {1'b0, SEG_7});
      tick(15);                                  // p=161
      check("s3_d0_sel", sel, 8'hFE);
      check("s3_d0_out", {1'b0, out}, {1'b0, SEG_2});
      tick(432);                                 // p=593
      check("s3_off7", {5'b0, offset}, 8'h07);
      tick(1);                                   // p=594
      check("s3_wrap", {5'b0, offset}, 8'h00);

      // Scenario 4: pause at offset 3 with 15 counts already in the timer
      tick(207);                                 // p=801
      check("s4_off3", {5'b0, offset}, 8'h03);
      pause = 1'b1;
      tick(200);                                 // p=1001
      check("s4_paused_off", {5'b0, offset}, 8'h03);
      check("s4_paused_sel", sel, 8'hFE);
      check("s4_paused_out", {1'b0, out}, {1'b0, SEG_4});
      pause = 1'b0;
      tick(48);                                  // p=1049
      check("s4_resume_pre", {5'b0, offset}, 8'h03);
      tick(1);                                   // p=1050
      check("s4_resume_step", {5'b0, offset}, 8'h04);

      // scroll_en low mid-interval: offset holds and the interval restarts
      tick(30);                                  // p=1080
      scroll_en = 1'b0;
      tick(50);                                  // p=1130
      check("dis_hold", {5'b0, offset}, 8'h04);
      scroll_en = 1'b1;
      tick(63);                                  // p=1193
      check("dis_restart_pre", {5'b0, offset}, 8'h04);
      tick(1);                                   // p=1194
      check("dis_restart_step", {5'b0, offset}, 8'h05);

      // Scenario 6: reset mid-SHOW of digit 5 at offset 2, during a load
      tick(353);                                 // p=1547
      check("s6_pre_sel", sel, 8'hDF);
      check("s6_pre_off", {5'b0, offset}, 8'h02);
      check("s6_pre_out", {1'b0, out}, {1'b0, SEG_8});
      scroll_en = 1'b0;
      load = 1'b1; load_idx = 3'd3; load_code = 4'h9;
      rst = 1'b1;
      #1;
      check("s6_async_sel", sel, 8'hFF);
      check("s6_async_out", {1'b0, out}, 8'h00);
      check("s6_async_off", {5'b0, offset}, 8'h00);
      tick(2);
      rst = 1'b0; load = 1'b0;
      check("s6_rel_sel", sel, 8'hFF);
      tick(1);
      check("s6_d0_sel", sel, 8'hFE);
      check("s6_d0_out", {1'b0, out}, {1'b0, SEG_0});
      for (int d = 1; d < 8; d++) begin
         tick(5);
         check("s6_scan_sel", sel, ~(8'b1 << d));
         check("s6_scan_out", {1'b0, out}, {1'b0, SEG_0});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
